// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for one synchronous RAM port: the CPU has priority, aux waits a bounded time,
// and the CPU can lock out aux for atomic sequences. Read data returns through a tag pipeline.
module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int MAX_AUX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_lock,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              locked
);

    localparam int               CNT_W    = $clog2(MAX_AUX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_AUX_WAIT);
    localparam logic             OWN_CPU  = 1'b0;
    localparam logic             OWN_AUX  = 1'b1;

    typedef enum logic {OPEN, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             sel_cpu, sel_aux;
    logic             vld_p [1:RD_LAT];
    logic             own_p [1:RD_LAT];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == WAIT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        sel_cpu   = 1'b0;
        sel_aux   = 1'b0;
        case (state)
            OPEN: begin
                if (cpu_req && aux_req) begin
                    if (wait_cnt == WAIT_MAX) sel_aux = 1'b1;
                    else                      sel_cpu = 1'b1;
                end else begin
                    sel_cpu = cpu_req;
                    sel_aux = aux_req;
                end
                if (sel_cpu && cpu_lock) state_nxt = LOCKED;
            end
            LOCKED: begin
                sel_cpu = cpu_req;
                if (!cpu_lock) state_nxt = OPEN;
            end
            default: state_nxt = OPEN;
        endcase
    end

    // Grants are masked while reset is held so nothing reaches the RAM mid-reset.
    assign cpu_gnt = sel_cpu & reset;
    assign aux_gnt = sel_aux & reset;
    assign locked  = (state == LOCKED);

    always_comb begin
        mem_en    = cpu_gnt | aux_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (aux_gnt) begin
            mem_we    = aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= OPEN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (aux_req && !aux_gnt) ? sat_inc(wait_cnt) : '0;
        end
    end

    // Stage 1..RD_LAT: read tag travels with the RAM latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_p[i] <= 1'b0;
                own_p[i] <= OWN_CPU;
            end
        end else begin
            vld_p[1] <= mem_en & ~mem_we;
            own_p[1] <= aux_gnt ? OWN_AUX : OWN_CPU;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                own_p[i] <= own_p[i-1];
            end
        end
    end

    // Return stage: capture RAM data into the owner's register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rvalid <= 1'b0;
            aux_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            aux_rdata  <= '0;
        end else begin
            cpu_rvalid <= vld_p[RD_LAT] && (own_p[RD_LAT] == OWN_CPU);
            aux_rvalid <= vld_p[RD_LAT] && (own_p[RD_LAT] == OWN_AUX);
            if (vld_p[RD_LAT] && (own_p[RD_LAT] == OWN_CPU)) cpu_rdata <= mem_rdata;
            if (vld_p[RD_LAT] && (own_p[RD_LAT] == OWN_AUX)) aux_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle grant table, read-return scoreboard against a RAM model,
// plus reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_lock, cpu_gnt, cpu_rvalid;
    logic [9:0]  cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        aux_req, aux_we, aux_gnt, aux_rvalid;
    logic [9:0]  aux_addr;
    logic [15:0] aux_wdata, aux_rdata;
    logic        mem_en, mem_we, locked;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] ram    [0:1023];
    logic [15:0] shadow [0:1023];

    typedef struct {
        logic        own;
        logic [15:0] data;
        int          due;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    typedef struct {
        logic        cr, cw;
        logic [9:0]  ca;
        logic [15:0] cd;
        logic        cl;
        logic        ar, aw;
        logic [9:0]  aa;
        logic [15:0] ad;
        logic        ec, ea, el;
    } vec_t;
    vec_t tbl[$];

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(16), .RD_LAT(1), .MAX_AUX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM, one cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic logic [15:0] init_val(input int a);
        return (a == 16) ? 16'hBEEF : 16'(16'h1000 + a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic cr, cw, input logic [9:0] ca, input logic [15:0] cd,
                                input logic cl, ar, aw, input logic [9:0] aa, input logic [15:0] ad,
                                input logic ec, ea, el);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.cl = cl;
        v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
        v.ec = ec; v.ea = ea; v.el = el;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd; cpu_lock = v.cl;
        aux_req = v.ar; aux_we = v.aw; aux_addr = v.aa; aux_wdata = v.ad;
    endtask

    // Predict read returns from the requesters' own fields and the bench's shadow memory
    task automatic expect_grants(input logic ec, input logic ea);
        sb_t e;
        if (ec) begin
            if (cpu_we) shadow[cpu_addr] = cpu_wdata;
            else begin
                e.own = 1'b0; e.data = shadow[cpu_addr]; e.due = cyc + 2;
                sb.push_back(e);
            end
        end
        if (ea) begin
            if (aux_we) shadow[aux_addr] = aux_wdata;
            else begin
                e.own = 1'b1; e.data = shadow[aux_addr]; e.due = cyc + 2;
                sb.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (cpu_rvalid || aux_rvalid) begin
                chk("rv_onehot", {31'd0, cpu_rvalid & aux_rvalid}, 0);
                if (sb.size() == 0) chk("unexpected_rvalid", {30'd0, cpu_rvalid, aux_rvalid}, 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("rv_owner", {31'd0, aux_rvalid}, {31'd0, mon_e.own});
                    chk("rv_cycle", cyc, mon_e.due);
                    chk("rv_data", aux_rvalid ? aux_rdata : cpu_rdata, mon_e.data);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("missed_rvalid", cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = init_val(i);
            shadow[i] = init_val(i);
        end
        // Grant table: one row per cycle; wait_cnt and lock state carry across rows
        tbl.push_back(mk(0,0,10'h000,16'h0,0, 0,0,10'h000,16'h0, 0,0,0));
        tbl.push_back(mk(0,0,10'h000,16'h0,0, 1,0,10'h020,16'h0, 0,1,0));
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 5; k++)
                tbl.push_back(mk(1,0,10'h030,16'h0,0, 1,0,10'h040,16'h0, k<4, k==4, 0));
        tbl.push_back(mk(1,1,10'h001,16'h1234,0, 1,0,10'h001,16'h0, 1,0,0));
        tbl.push_back(mk(0,0,10'h000,16'h0,0, 1,0,10'h001,16'h0, 0,1,0));
        tbl.push_back(mk(1,0,10'h002,16'h0,1, 1,0,10'h040,16'h0, 1,0,0));
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(k==3,0,10'h003,16'h0,1, 1,0,10'h040,16'h0, k==3,0,1));
        tbl.push_back(mk(0,0,10'h000,16'h0,0, 1,0,10'h040,16'h0, 0,0,1));
        tbl.push_back(mk(1,0,10'h004,16'h0,0, 1,0,10'h005,16'h0, 0,1,0));
        tbl.push_back(mk(1,0,10'h004,16'h0,0, 0,0,10'h000,16'h0, 1,0,0));
        tbl.push_back(mk(0,0,10'h000,16'h0,1, 0,0,10'h000,16'h0, 0,0,0));
        tbl.push_back(mk(0,0,10'h000,16'h0,1, 1,0,10'h006,16'h0, 0,1,0));
        tbl.push_back(mk(1,0,10'h001,16'h0,0, 0,0,10'h000,16'h0, 1,0,0));
        tbl.push_back(mk(0,0,10'h000,16'h0,0, 1,0,10'h002,16'h0, 0,1,0));
        tbl.push_back(mk(1,1,10'h001,16'h5A5A,0, 0,0,10'h000,16'h0, 1,0,0));
        tbl.push_back(mk(0,0,10'h000,16'h0,0, 1,0,10'h001,16'h0, 0,1,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,0,10'h000,16'h0,0, 0,0,10'h000,16'h0, 0,0,0));

        // Reset held with a pending CPU read request
        reset = 1'b0;
        drive(mk(1,0,10'h010,16'h0,0, 0,0,10'h000,16'h0, 0,0,0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rvalid", {cpu_rvalid, aux_rvalid}, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_locked", locked, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_cpu_gnt", cpu_gnt, 1);
        chk("rel_mem_addr", mem_addr, 10'h010);
        expect_grants(1'b1, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("r%0d_cpu_gnt", i), cpu_gnt, tbl[i].ec);
            chk($sformatf("r%0d_aux_gnt", i), aux_gnt, tbl[i].ea);
            chk($sformatf("r%0d_locked", i), locked, tbl[i].el);
            chk($sformatf("r%0d_mem_en", i), mem_en, tbl[i].ec | tbl[i].ea);
            if (tbl[i].ec) begin
                chk($sformatf("r%0d_mem_addr", i), mem_addr, tbl[i].ca);
                chk($sformatf("r%0d_mem_we", i), mem_we, tbl[i].cw);
            end else if (tbl[i].ea) begin
                chk($sformatf("r%0d_mem_addr", i), mem_addr, tbl[i].aa);
                chk($sformatf("r%0d_mem_we", i), mem_we, tbl[i].aw);
            end else begin
                chk($sformatf("r%0d_mem_we", i), mem_we, 0);
            end
            expect_grants(tbl[i].ec, tbl[i].ea);
        end

        // Abort: aux read granted, reset asserted during the following cycle
        @(posedge clk); #1;
        drive(mk(0,0,10'h000,16'h0,0, 1,0,10'h020,16'h0, 0,0,0));
        @(negedge clk);
        chk("abort_aux_gnt", aux_gnt, 1);
        @(posedge clk); #1;
        drive(mk(1,0,10'h030,16'h0,0, 1,0,10'h040,16'h0, 0,0,0));
        @(negedge clk); #1;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("abort_gnt", {cpu_gnt, aux_gnt}, 0);
        chk("abort_mem_en", mem_en, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_rvalid", {cpu_rvalid, aux_rvalid}, 0);
        chk("abort_aux_rdata", aux_rdata, 0);
        chk("abort_wait_cnt", {29'd0, dut.wait_cnt}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("post_cpu_gnt%0d", k), cpu_gnt, k < 4);
            chk($sformatf("post_aux_gnt%0d", k), aux_gnt, k == 4);
            expect_grants(k < 4, k == 4);
            @(posedge clk); #1;
        end
        drive(mk(0,0,10'h000,16'h0,0, 0,0,10'h000,16'h0, 0,0,0));
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
